// File: rtl/mips_cpu_data_memory.sv
// mips_cpu_data_memory
// Word-organised data RAM for the data port of the Harvard MIPS CPU.
// Writes are clocked; reads are combinational, so the CPU gets load data in
// the same cycle it raises data_read. Byte addresses are translated to word
// indices relative to ADDR_BASE, and the two low address bits are ignored.
//
// Optional build macro: MIPS_DMEM_WRITE_FORWARD_EN
//   Defined   : a read and a write issued together (clk_enable high, address
//               in range) return data_writedata straight away (store-to-load
//               bypass).
//   Undefined : data_readdata always shows the stored array contents.
//
// Port interface (valid/ready semantics): there is no handshake. data_read
// and data_write are single-cycle strobes. A read is answered in the same
// cycle. A write commits on the rising clk edge on which it is held, provided
// clk_enable is high and reset is low.
module mips_cpu_data_memory #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic        data_write,
    input  logic        data_read,
    input  logic        reset,
    output logic [31:0] data_readdata
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Window size in bytes. It is held in 33 bits so the range compare can
    // never wrap, whatever the depth.
    localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          in_range;
    logic          write_en;

    logic [31:0] mem_q [DEPTH_WORDS];

    // The offset from the window base drives both the range check and the
    // word index. Because the check uses the full 32-bit offset, an address
    // beyond the window can never alias back onto a valid word.
    assign offset   = data_address - ADDR_BASE;
    assign index    = offset[AW+1:2];
    assign in_range = ({1'b0, offset} < LIMIT_BYTES);

    // The strobe is part of the condition, so an X address cannot corrupt
    // the array while data_write is low.
    assign write_en = clk_enable && data_write && in_range && !reset;

    // Array storage: reset clears every word asynchronously; an enabled,
    // in-range store updates one word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[index] <= data_writedata;
        end
    end

    // Combinational load path: returns zero unless a valid, in-range read
    // is requested outside reset.
    always_comb begin
        data_readdata = '0;
        if (data_read && in_range && !reset) begin
            data_readdata = mem_q[index];
`ifdef MIPS_DMEM_WRITE_FORWARD_EN
            // Reads and writes share one address port, so their word indices
            // always match. A store issued alongside the load is bypassed.
            if (data_write && clk_enable) begin
                data_readdata = data_writedata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_cpu_data_memory.sv
// tb_mips_cpu_data_memory
// Directed and randomized checks of mips_cpu_data_memory against a
// word-array reference model indexed by (address - base) / 4.
module tb_mips_cpu_data_memory;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_writedata = '0;
  logic        data_write = 1'b0;
  logic        data_read = 1'b0;
  logic [31:0] data_readdata;

  always #5 clk = ~clk;

  mips_cpu_data_memory #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_BASE  (BASE)
  ) dut (
    .clk           (clk),
    .clk_enable    (clk_enable),
    .data_address  (data_address),
    .data_writedata(data_writedata),
    .data_write    (data_write),
    .data_read     (data_read),
    .reset         (reset),
    .data_readdata (data_readdata)
  );

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  function automatic bit model_in_range(input logic [31:0] addr);
    longint unsigned off;
    off = (longint'(addr) - longint'(BASE)) & 64'hFFFF_FFFF;
    return off < longint'(4 * DEPTH);
  endfunction

  function automatic int model_index(input logic [31:0] addr);
    longint unsigned off;
    off = (longint'(addr) - longint'(BASE)) & 64'hFFFF_FFFF;
    return int'(off / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (model_in_range(addr)) return model_mem[model_index(addr)];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One bus cycle: drive at the falling edge, check the combinational read
  // before the rising edge, let the edge commit, then check again after it.
  task automatic bus_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic we, input logic re, input logic ce, input bit post_check);
    logic [31:0] exp_pre;
    @(negedge clk);
    data_address   = addr;
    data_writedata = wd;
    data_write     = we;
    data_read      = re;
    clk_enable     = ce;
    #1;
    exp_pre = re ? model_read(addr) : 32'h0;
`ifdef MIPS_DMEM_WRITE_FORWARD_EN
    if (re && we && ce && model_in_range(addr)) exp_pre = wd;
`endif
    check({tag, "_pre"}, data_readdata, exp_pre);
    @(posedge clk);
    if (we && ce && model_in_range(addr)) model_mem[model_index(addr)] = wd;
    #1;
    if (post_check) check({tag, "_post"}, data_readdata, re ? model_read(addr) : 32'h0);
    data_write = 1'b0;
    data_read  = 1'b0;
    clk_enable = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd);
    bus_op("wr", addr, wd, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr);
    bus_op(tag, addr, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    model_clear();

    // Reading while reset is held must give zero.
    data_read    = 1'b1;
    data_address = 32'h10;
    #3;
    check("reset_read", data_readdata, 32'h0);
    #9 reset = 1'b0;
    data_read  = 1'b0;
    clk_enable = 1'b1;

    // Fill some words, then clear them with a 1 ns mid-cycle reset pulse.
    do_write(32'h0,   32'h1111_1111);
    do_write(32'h10,  32'h2222_2222);
    do_write(32'hFFC, 32'h3333_3333);
    do_read("prefill_10", 32'h10);
    @(negedge clk);
    #2;
    data_read    = 1'b1;
    data_address = 32'hFFC;
    reset        = 1'b1;
    #0.5;
    check("reset_mid_read", data_readdata, 32'h0);
    #0.5;
    reset = 1'b0;
    data_read = 1'b0;
    model_clear();
    do_read("rst_0",   32'h0);
    do_read("rst_10",  32'h10);
    do_read("rst_ffc", 32'hFFC);

    // sw then lw of 0xFFFF0.
    do_write(32'h10, 32'h000F_FFF0);
    do_read("sw_lw_10", 32'h10);

    // With clk_enable low, writes are blocked but reads still work.
    do_write(32'h24, 32'h0000_0055);
    bus_op("ce0_wr20", 32'h20, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_op("ce0_rd24", 32'h24, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_read("ce1_rd20", 32'h20);

    // Misaligned addresses act on the containing word.
    do_write(32'h22, 32'h1234_5678);
    do_read("mis_20", 32'h20);
    do_read("mis_23", 32'h23);
    bus_op("noread_20", 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Out-of-range writes are dropped and do not alias onto valid words.
    do_write(32'h1000, 32'h7777_7777);
    do_write(32'hFFFF_FFFC, 32'h8888_8888);
    do_read("oor_1000", 32'h1000);
    do_read("oor_0", 32'h0);
    do_read("oor_ffc", 32'hFFC);

    // Read and write to the same word in one cycle.
    bus_op("rw_40", 32'h40, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 1'b1);

    // An X address with both strobes low must leave the array untouched.
    @(negedge clk);
    data_address   = 'x;
    data_writedata = 'x;
    data_write     = 1'b0;
    data_read      = 1'b0;
    repeat (3) @(posedge clk);
    do_read("xaddr_10", 32'h10);
    do_read("xaddr_40", 32'h40);

    // Randomized traffic, with some addresses just beyond the window.
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(0, 4 * DEPTH + 64);
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 3) == 0 ? 30'($urandom) : 30'($urandom_range(0, 32)), 2'($urandom)};
      d = $urandom;
      bus_op("rand", a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 4) != 0), 1'b1);
    end

    // Read back a sample of the low words after the random traffic.
    for (int i = 0; i < 32; i++) do_read("sweep", 32'(i * 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
